// File: rtl/spi_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter_if
// Brief    : Client and spi_module side signals of the SPI arbiter, bundled.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int SPI_WORD_LEN = 8,
  parameter int LEN_W        = 8
) ();
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ*LEN_W-1:0]        req_words;
  logic [NUM_REQ*SPI_WORD_LEN-1:0] tx_data;
  logic [NUM_REQ-1:0]              grant;
  logic [NUM_REQ-1:0]              tx_ack;
  logic [SPI_WORD_LEN-1:0]         rx_data;
  logic [NUM_REQ-1:0]              rx_valid;
  logic [NUM_REQ-1:0]              done;
  logic [NUM_REQ-1:0]              error;
  logic                            busy;
  logic                            spi_process_next_word;
  logic [SPI_WORD_LEN-1:0]         spi_data_word_send;
  logic                            spi_processing_word;
  logic [SPI_WORD_LEN-1:0]         spi_data_word_recv;
  logic                            spi_is_ready;

  modport master (
    input  req, req_words, tx_data,
    input  spi_processing_word, spi_data_word_recv, spi_is_ready,
    output grant, tx_ack, rx_data, rx_valid, done, error, busy,
    output spi_process_next_word, spi_data_word_send
  );

  modport slave (
    output req, req_words, tx_data,
    output spi_processing_word, spi_data_word_recv, spi_is_ready,
    input  grant, tx_ack, rx_data, rx_valid, done, error, busy,
    input  spi_process_next_word, spi_data_word_send
  );
endinterface
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_arbiter
// Brief    : Round-robin sharing of one spi_module among NUM_REQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module spi_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int SPI_WORD_LEN   = 8,
  parameter int LEN_W          = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int LAUNCH_TIMEOUT = 1024
) (
  input  logic          master_clock,
  input  logic          do_reset,
  spi_arbiter_if.master bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_W  = $clog2(LAUNCH_TIMEOUT);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TO_W-1:0]    TO_LAST  = TO_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_BUSY    = 3'd2,
    S_CAPTURE = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5,
    S_ABORT   = 3'd6
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  win;
  logic [IDX_W-1:0]  cand;
  logic              win_found;
  logic [LEN_W-1:0]  remaining;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic [LEN_W-1:0]        words_arr [NUM_REQ];
  logic [SPI_WORD_LEN-1:0] tx_arr    [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words_arr[i] = bus.req_words[i*LEN_W +: LEN_W];
    assign tx_arr[i]    = bus.tx_data[i*SPI_WORD_LEN +: SPI_WORD_LEN];
  end

  // Search starts just after the last winner so every pending requester is served once per round.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && bus.req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge master_clock or posedge do_reset) begin
    if (do_reset) begin
      state                     <= S_IDLE;
      rr_ptr                    <= IDX_W'(NUM_REQ - 1);
      idx                       <= '0;
      remaining                 <= '0;
      to_cnt                    <= '0;
      gap_cnt                   <= '0;
      bus.grant                 <= '0;
      bus.tx_ack                <= '0;
      bus.rx_data               <= '0;
      bus.rx_valid              <= '0;
      bus.done                  <= '0;
      bus.error                 <= '0;
      bus.busy                  <= 1'b0;
      bus.spi_process_next_word <= 1'b0;
      bus.spi_data_word_send    <= '0;
    end else begin
      bus.tx_ack   <= '0;
      bus.rx_valid <= '0;
      bus.done     <= '0;
      bus.error    <= '0;
      // busy rises with the grant and stays up through the done/error pulse cycle
      bus.busy     <= (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (bus.spi_is_ready && win_found) begin
            bus.grant <= ONE << win;
            bus.busy  <= 1'b1;
            idx       <= win;
            rr_ptr    <= win;
            remaining <= words_arr[win];
            if (words_arr[win] == '0) begin
              state <= S_DONE;
            end else begin
              bus.spi_data_word_send <= tx_arr[win];
              bus.tx_ack             <= ONE << win;
              to_cnt                 <= '0;
              state                  <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          if (bus.spi_processing_word) begin
            bus.spi_process_next_word <= 1'b0;
            state                     <= S_BUSY;
          end else if (to_cnt + TO_W'(1) == TO_LAST) begin
            bus.spi_process_next_word <= 1'b0;
            state                     <= S_ABORT;
          end else begin
            bus.spi_process_next_word <= 1'b1;
            to_cnt                    <= to_cnt + TO_W'(1);
          end
        end
        S_BUSY: begin
          if (!bus.spi_processing_word) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          bus.rx_data  <= bus.spi_data_word_recv;
          bus.rx_valid <= ONE << idx;
          remaining    <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state <= S_DONE;
          end else if (GAP_CYCLES == 0) begin
            bus.spi_data_word_send <= tx_arr[idx];
            bus.tx_ack             <= ONE << idx;
            to_cnt                 <= '0;
            state                  <= S_LAUNCH;
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            bus.spi_data_word_send <= tx_arr[idx];
            bus.tx_ack             <= ONE << idx;
            to_cnt                 <= '0;
            state                  <= S_LAUNCH;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        S_DONE: begin
          bus.done  <= ONE << idx;
          bus.grant <= '0;
          state     <= S_IDLE;
        end
        S_ABORT: begin
          bus.error                 <= ONE << idx;
          bus.grant                 <= '0;
          bus.spi_process_next_word <= 1'b0;
          state                     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_arbiter
// Brief    : Directed scoreboard bench for spi_arbiter with a loopback SPI model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_arbiter;
  localparam int NR  = 4;
  localparam int WL  = 8;
  localparam int LW  = 8;
  localparam int GAP = 2;
  localparam int TO  = 16;
  localparam int K_GNT = 1, K_ACK = 2, K_RXV = 3, K_DONE = 4, K_ERR = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spi_arbiter_if #(.NUM_REQ(NR), .SPI_WORD_LEN(WL), .LEN_W(LW)) bus ();

  spi_arbiter #(
    .NUM_REQ(NR), .SPI_WORD_LEN(WL), .LEN_W(LW),
    .GAP_CYCLES(GAP), .LAUNCH_TIMEOUT(TO)
  ) dut (
    .master_clock(clk),
    .do_reset(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] expq[$];

  logic [WL-1:0] words [NR][8];
  logic [2:0]    txk   [NR] = '{default: 3'd0};
  logic [2:0]    ek    [NR] = '{default: 3'd0};

  // Requesters present words[i][txk[i]] and advance after each tx_ack.
  always_comb begin
    bus.tx_data = '0;
    for (int i = 0; i < NR; i++) bus.tx_data[i*WL +: WL] = words[i][txk[i]];
  end
  always @(negedge clk) begin
    for (int i = 0; i < NR; i++) if (bus.tx_ack[i]) txk[i] <= txk[i] + 3'd1;
  end

  // Loopback spi_module model: alignment delay, busy window, then MISO = MOSI.
  logic          spi_dead = 1'b0;
  logic [1:0]    mst;
  int            mcnt;
  logic [WL-1:0] shreg;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mst <= 2'd0; mcnt <= 0; shreg <= '0;
      bus.spi_processing_word <= 1'b0;
      bus.spi_data_word_recv  <= '0;
    end else if (!spi_dead) begin
      case (mst)
        2'd0: if (bus.spi_process_next_word) begin mst <= 2'd1; mcnt <= 2; end
        2'd1: if (mcnt == 0) begin
                bus.spi_processing_word <= 1'b1; shreg <= bus.spi_data_word_send;
                mst <= 2'd2; mcnt <= 5;
              end else mcnt <= mcnt - 1;
        2'd2: if (mcnt == 0) begin
                bus.spi_processing_word <= 1'b0; bus.spi_data_word_recv <= shreg;
                mst <= 2'd0;
              end else mcnt <= mcnt - 1;
        default: mst <= 2'd0;
      endcase
    end
  end
  assign bus.spi_is_ready = (mst == 2'd0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mk(input int k, input int r, input int d);
    return {8'(k), 8'(r), 16'(d)};
  endfunction

  task automatic check_ev(input logic [31:0] obs);
    logic [31:0] e;
    e = (expq.size() != 0) ? expq.pop_front() : 32'hFFFF_FFFF;
    n_checks++;
    assert (obs === e) n_pass++;
    else $error("FAIL event: observed %h required %h", obs, e);
  endtask

  task automatic push_gnt(input int r);
    expq.push_back(mk(K_GNT, 0, 1 << r));
  endtask
  task automatic push_ack(input int r);
    expq.push_back(mk(K_ACK, r, int'(words[r][ek[r]])));
    ek[r] = ek[r] + 3'd1;
  endtask
  task automatic push_txn(input int r, input int n);
    push_gnt(r);
    for (int j = 0; j < n; j++) begin
      push_ack(r);
      expq.push_back(mk(K_RXV, r, int'(words[r][ek[r] - 3'd1])));
    end
    expq.push_back(mk(K_DONE, r, 0));
  endtask

  // Monitor: turns DUT pulses into events and checks them against the scoreboard.
  logic [NR-1:0] prev_grant = '0;
  logic prev_proc = 1'b0, prev_pnw = 1'b0, gap_run = 1'b0, pnw_seen = 1'b0;
  int   gap_n = 0, min_gap = 999;
  always @(negedge clk) begin
    if (rst) begin
      prev_grant = '0; prev_proc = 1'b0; prev_pnw = 1'b0; gap_run = 1'b0;
    end else begin
      if (prev_grant == '0 && bus.grant != '0) begin
        check_ev(mk(K_GNT, 0, int'(bus.grant)));
        check("grant_onehot", 32'($onehot(bus.grant)), 32'd1);
      end
      for (int i = 0; i < NR; i++) if (bus.tx_ack[i])   check_ev(mk(K_ACK, i, int'(bus.spi_data_word_send)));
      for (int i = 0; i < NR; i++) if (bus.rx_valid[i]) check_ev(mk(K_RXV, i, int'(bus.rx_data)));
      for (int i = 0; i < NR; i++) if (bus.done[i])     check_ev(mk(K_DONE, i, 0));
      for (int i = 0; i < NR; i++) if (bus.error[i])    check_ev(mk(K_ERR, i, 0));
      if (prev_proc && !bus.spi_processing_word) begin gap_run = 1'b1; gap_n = 0; end
      else if (gap_run) gap_n++;
      if (!prev_pnw && bus.spi_process_next_word && gap_run) begin
        if (gap_n < min_gap) min_gap = gap_n;
        gap_run = 1'b0;
      end
      if (bus.spi_process_next_word) pnw_seen = 1'b1;
      prev_grant = bus.grant;
      prev_proc  = bus.spi_processing_word;
      prev_pnw   = bus.spi_process_next_word;
    end
  end

  function automatic logic sig(input int sel, input int r);
    case (sel)
      0:       return bus.done[r];
      1:       return bus.grant == (NR'(1) << r);
      2:       return bus.spi_processing_word;
      3:       return bus.tx_ack[r];
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int r, input string tag);
    int n = 0;
    while (!sig(sel, r) && n < 2000) begin @(negedge clk); n++; end
    check(tag, 32'(sig(sel, r)), 32'd1);
  endtask

  initial begin
    int n;
    words[0] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    words[1] = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57};
    words[2] = '{8'h60, 8'h61, 8'h11, 8'h22, 8'h33, 8'h65, 8'h66, 8'h67};
    words[3] = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77};
    bus.req = '0; bus.req_words = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_grant",  32'(bus.grant), 0);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_pnw",    32'(bus.spi_process_next_word), 0);
    check("rst_pulses", 32'({bus.tx_ack, bus.rx_valid, bus.done, bus.error}), 0);
    check("rst_rx",     32'(bus.rx_data), 0);
    check("rst_send",   32'(bus.spi_data_word_send), 0);
    rst = 1'b0;
    @(negedge clk);

    // Round robin: all four requesting two words each
    bus.req_words = {8'd2, 8'd2, 8'd2, 8'd2};
    push_txn(0, 2); push_txn(1, 2); push_txn(2, 2); push_txn(3, 2); push_txn(0, 2);
    bus.req = 4'b1111;
    for (int r = 0; r < NR; r++) wait_until(0, r, "rr_done");
    @(negedge clk);
    wait_until(1, 0, "rr_regrant0");
    bus.req = '0;
    wait_until(0, 0, "rr_done_last");
    @(negedge clk);
    check("rr_queue", 32'(expq.size()), 0);

    // Single word, loopback of A5
    bus.req_words = {8'd0, 8'd0, 8'd0, 8'd1};
    push_txn(0, 1);
    bus.req = 4'b0001;
    @(posedge clk); #1;
    check("sw_ack_latency", 32'({bus.grant, bus.tx_ack}), 32'h11);
    @(posedge clk); #1;
    check("sw_launch_latency", 32'(bus.spi_process_next_word), 1);
    @(negedge clk);
    bus.req = '0;
    wait_until(0, 0, "sw_done");
    @(negedge clk);
    check("sw_grant_release", 32'(bus.grant), 0);

    // Multi-word with inter-word gap on requester 2
    bus.req_words = {8'd0, 8'd3, 8'd0, 8'd0};
    min_gap = 999;
    push_txn(2, 3);
    bus.req = 4'b0100;
    @(negedge clk);
    bus.req = '0;
    wait_until(0, 2, "mw_done");
    check("mw_gap_ok", 32'(min_gap >= GAP && min_gap < 999), 1);

    // Zero-length request on requester 1
    @(negedge clk);
    bus.req_words = '0;
    pnw_seen = 1'b0;
    push_txn(1, 0);
    bus.req = 4'b0010;
    @(posedge clk); #1;
    check("zl_done_early", 32'(bus.done), 0);
    @(posedge clk); #1;
    check("zl_done", 32'(bus.done), 32'b0010);
    @(negedge clk);
    bus.req = '0;
    repeat (2) @(negedge clk);
    check("zl_no_pnw", 32'(pnw_seen), 0);

    // Launch timeout: spi_module never starts a word
    spi_dead = 1'b1;
    bus.req_words = {8'd0, 8'd0, 8'd0, 8'd1};
    push_gnt(0); push_ack(0); expq.push_back(mk(K_ERR, 0, 0));
    bus.req = 4'b0001;
    wait_until(3, 0, "to_launch");
    bus.req = '0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!bus.error[0] && n < 100);
    check("to_latency", 32'(n), 32'(TO));
    check("to_busy_hold", 32'(bus.busy), 1);
    @(posedge clk); #1;
    check("to_busy_fall", 32'(bus.busy), 0);
    spi_dead = 1'b0;
    repeat (3) @(negedge clk);
    check("to_queue", 32'(expq.size()), 0);

    // Reset while spi_module is mid-word
    bus.req_words = {8'd0, 8'd0, 8'd0, 8'd3};
    push_gnt(0); push_ack(0);
    bus.req = 4'b0001;
    wait_until(2, 0, "rw_proc");
    bus.req = '0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rw_async", 32'({bus.grant, bus.busy, bus.spi_process_next_word}), 0);
    check("rw_queue", 32'(expq.size()), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.req_words = {8'd0, 8'd0, 8'd1, 8'd1};
    push_txn(0, 1); push_txn(1, 1);
    bus.req = 4'b0011;
    wait_until(1, 1, "rw_grant1");
    bus.req = '0;
    wait_until(0, 1, "rw_done1");
    @(negedge clk);
    check("final_queue", 32'(expq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
